// File: rtl/add_sched.sv
// add_sched: round-robin word-serial scheduler sharing one 16-bit carry-select adder among N_REQ requesters.
// Define ADD_SCHED_OVF_EN to build the signed-overflow flag on the final word; otherwise res_ovf is tied low.
module add_sched #(
    parameter int N_REQ     = 4,
    parameter int MAX_WORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [16*N_REQ-1:0]      req_a,
    input  logic [16*N_REQ-1:0]      req_b,
    input  logic [N_REQ-1:0]         req_cin,
    input  logic [N_REQ-1:0]         req_last,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [15:0]              res_y,
    output logic                     res_cout,
    output logic [$clog2(N_REQ)-1:0] res_id,
    output logic                     res_last,
    output logic                     res_ovf
);
    localparam int IW = $clog2(N_REQ);
    localparam int WW = $clog2(MAX_WORDS) + 1;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]    state;
    logic [IW-1:0] ptr, grant, pick, idx;
    logic [WW-1:0] wcnt;
    logic          first, creg, go, accept, last, cin, cout;
    logic [15:0]   a, b, sum;
    logic [8:0]    lo, hi0, hi1;
    logic [15:0]   a_arr [N_REQ];
    logic [15:0]   b_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign a_arr[g] = req_a[16*g +: 16];
        assign b_arr[g] = req_b[16*g +: 16];
    end

    assign go        = (state == BUSY) & (~res_valid | res_ready);
    assign req_ready = go ? (N_REQ'(1) << grant) : '0;
    assign accept    = go & req_valid[grant];
    assign a         = a_arr[grant];
    assign b         = b_arr[grant];
    assign last      = req_last[grant] | (wcnt == WW'(MAX_WORDS - 1));
    assign cin       = first ? req_cin[grant] : creg;

    // Carry-select: upper byte is precomputed for both carries, low-byte carry picks one.
    assign lo   = {1'b0, a[7:0]} + {1'b0, b[7:0]} + {8'd0, cin};
    assign hi0  = {1'b0, a[15:8]} + {1'b0, b[15:8]};
    assign hi1  = hi0 + 9'd1;
    assign sum  = {lo[8] ? hi1[7:0] : hi0[7:0], lo[7:0]};
    assign cout = lo[8] ? hi1[8] : hi0[8];

    // Scanning from the farthest offset down leaves the nearest valid requester after ptr.
    always_comb begin
        pick = ptr;
        idx  = ptr;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = IW'((int'(ptr) + k) % N_REQ);
            if (req_valid[idx]) pick = idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= IW'(N_REQ - 1);
            grant     <= '0;
            first     <= 1'b1;
            creg      <= 1'b0;
            wcnt      <= '0;
            res_valid <= 1'b0;
            res_y     <= '0;
            res_cout  <= 1'b0;
            res_id    <= '0;
            res_last  <= 1'b0;
        end else begin
            if (accept) begin
                res_valid <= 1'b1;
                res_y     <= sum;
                res_cout  <= cout;
                res_id    <= grant;
                res_last  <= last;
                creg      <= cout;
                first     <= 1'b0;
                wcnt      <= wcnt + 1'b1;
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
            if (state == IDLE && |req_valid) begin
                grant <= pick;
                first <= 1'b1;
                wcnt  <= '0;
                state <= BUSY;
            end
            if (accept && last) begin
                ptr   <= grant;
                state <= IDLE;
            end
        end
    end

`ifdef ADD_SCHED_OVF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) res_ovf <= 1'b0;
        else if (accept) res_ovf <= last & (a[15] == b[15]) & (sum[15] != a[15]);
    end
`else
    assign res_ovf = 1'b0;
`endif
endmodule

// File: tb/tb_add_sched.sv
// tb_add_sched: directed stimulus for add_sched with a per-requester multi-word arithmetic model
// and a per-cycle compare process; honours ADD_SCHED_OVF_EN for the overflow expectation.
module tb_add_sched;
    localparam int N  = 4;
    localparam int MW = 4;
`ifdef ADD_SCHED_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid, req_ready, req_cin, req_last;
    logic [16*N-1:0] req_a, req_b;
    logic           res_valid, res_ready, res_cout, res_last, res_ovf;
    logic [15:0]    res_y;
    logic [1:0]     res_id;

    add_sched #(.N_REQ(N), .MAX_WORDS(MW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_last(req_last),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_y(res_y), .res_cout(res_cout), .res_id(res_id),
        .res_last(res_last), .res_ovf(res_ovf)
    );

    always #5 clk = ~clk;

    // sq: pending words {last,cin,a,b}; expq: expected results {ovf,last,cout,y}; log_q: observed {id,ovf,last,cout,y}
    logic [33:0] sq   [N][$];
    logic [18:0] expq [N][$];
    logic [20:0] log_q[$];
    logic        mfirst [N];
    logic        mcar   [N];
    int          mcnt   [N];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic        hold = 1'b0;
    logic [21:0] prev;
    logic [18:0] e_cmp;
    logic [15:0] t2y [3] = '{16'h0000, 16'h0000, 16'h0001};
    logic        t2c [3] = '{1'b1, 1'b1, 1'b0};
    logic        t2l [3] = '{1'b0, 1'b0, 1'b1};
    logic [1:0]  t3id[6] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
    logic [1:0]  t5id[5] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
    logic        t5l [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] t5y [5] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0300};
    int          n;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive();
        logic [33:0] w;
        for (int i = 0; i < N; i++) begin
            w = (sq[i].size() > 0) ? sq[i][0] : '0;
            req_valid[i]       = sq[i].size() > 0;
            req_last[i]        = w[33];
            req_cin[i]         = w[32];
            req_a[16*i +: 16]  = w[31:16];
            req_b[16*i +: 16]  = w[15:0];
        end
    endtask

    // Model: each requester's stream is a multi-word sum with carry chaining and a MW-word cut.
    task automatic push(int i, logic [15:0] a, logic [15:0] b, logic c, logic l);
        logic [16:0] s;
        logic ci, lst;
        sq[i].push_back({l, c, a, b});
        ci  = mfirst[i] ? c : mcar[i];
        s   = {1'b0, a} + {1'b0, b} + {16'd0, ci};
        lst = l || (mcnt[i] == MW - 1);
        expq[i].push_back({OVF_EN & lst & (a[15] == b[15]) & (s[15] != a[15]), lst, s[16], s[15:0]});
        mcar[i]   = s[16];
        mfirst[i] = lst;
        mcnt[i]   = lst ? 0 : mcnt[i] + 1;
        drive();
    endtask

    task automatic tick();
        logic [N-1:0] acc;
        logic [33:0]  w;
        @(negedge clk);
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (acc[i] && sq[i].size() > 0) w = sq[i].pop_front();
        drive();
    endtask

    function automatic bit pending();
        bit p = 1'b0;
        for (int i = 0; i < N; i++) p |= (sq[i].size() > 0) || (expq[i].size() > 0);
        return p;
    endfunction

    task automatic wait_idle();
        int k = 0;
        while (pending() && k < 300) begin
            tick();
            k++;
        end
        chk("drain within budget", k < 300, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        @(posedge clk);
        #1;
        chk("reset res_valid", res_valid, 0);
        chk("reset res_y", res_y, 0);
        chk("reset res_cout", res_cout, 0);
        chk("reset res_id", res_id, 0);
        chk("reset res_last", res_last, 0);
        chk("reset res_ovf", res_ovf, 0);
        chk("reset req_ready", req_ready, 0);
        for (int i = 0; i < N; i++) begin
            sq[i].delete();
            expq[i].delete();
            mfirst[i] = 1'b1;
            mcar[i]   = 1'b0;
            mcnt[i]   = 0;
        end
        drive();
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            hold = 1'b0;
        end else begin
            chk("req_ready at most one hot", $countones(req_ready) <= 1, 1);
            if (hold) chk("result held under backpressure", {res_valid, res_y, res_cout, res_id, res_last, res_ovf}, prev);
            if (res_valid && res_ready) begin
                chk("result expected for res_id", expq[res_id].size() > 0, 1);
                if (expq[res_id].size() > 0) begin
                    e_cmp = expq[res_id].pop_front();
                    chk("res_y", res_y, e_cmp[15:0]);
                    chk("res_cout", res_cout, e_cmp[16]);
                    chk("res_last", res_last, e_cmp[17]);
                    chk("res_ovf", res_ovf, e_cmp[18]);
                end
                log_q.push_back({res_id, res_ovf, res_last, res_cout, res_y});
            end
            hold = res_valid & ~res_ready;
            prev = {res_valid, res_y, res_cout, res_id, res_last, res_ovf};
        end
    end

    initial begin
        req_valid = '0; req_ready_init();
        res_ready = 1'b1;
        do_reset();

        push(0, 16'h1234, 16'h0001, 1'b0, 1'b1);
        tick();
        chk("t1 no result during arbitration", res_valid, 0);
        tick();
        chk("t1 res_valid", res_valid, 1);
        chk("t1 res_y", res_y, 16'h1235);
        chk("t1 res_cout", res_cout, 0);
        chk("t1 res_id", res_id, 0);
        chk("t1 res_last", res_last, 1);
        wait_idle();

        log_q.delete();
        push(2, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        push(2, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
        push(2, 16'h0000, 16'h0000, 1'b0, 1'b1);
        wait_idle();
        chk("t2 result count", log_q.size(), 3);
        for (int k = 0; k < 3; k++) begin
            chk("t2 chain y", log_q[k][15:0], t2y[k]);
            chk("t2 chain cout", log_q[k][16], t2c[k]);
            chk("t2 chain last", log_q[k][17], t2l[k]);
            chk("t2 chain id", log_q[k][20:19], 2);
        end

        do_reset();
        log_q.delete();
        for (int r = 0; r < 2; r++) begin
            push(0, 16'h0010 + 16'(r), 16'h0001, 1'b0, 1'b1);
            push(1, 16'h0020 + 16'(r), 16'h0002, 1'b0, 1'b1);
            push(3, 16'h0030 + 16'(r), 16'h0003, 1'b0, 1'b1);
        end
        wait_idle();
        chk("t3 result count", log_q.size(), 6);
        for (int k = 0; k < 6; k++) chk("t3 round-robin id", log_q[k][20:19], t3id[k]);

        log_q.delete();
        push(0, 16'hFFFF, 16'h0002, 1'b0, 1'b0);
        push(0, 16'h0010, 16'h0020, 1'b0, 1'b1);
        n = 0;
        while (!res_valid && n < 20) begin
            tick();
            n++;
        end
        chk("t4 first result arrives", res_valid, 1);
        res_ready = 1'b0;
        repeat (3) tick();
        chk("t4 req_ready dropped", req_ready, 0);
        chk("t4 held res_y", res_y, 16'h0001);
        chk("t4 held res_cout", res_cout, 1);
        res_ready = 1'b1;
        #1;
        chk("t4 req_ready restored", req_ready, 4'b0001);
        tick();
        chk("t4 second res_valid", res_valid, 1);
        chk("t4 second res_y", res_y, 16'h0031);
        chk("t4 second res_cout", res_cout, 0);
        chk("t4 second res_last", res_last, 1);
        wait_idle();

        log_q.delete();
        push(1, 16'hFFFF, 16'h0001, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) push(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        push(2, 16'h0100, 16'h0200, 1'b0, 1'b1);
        n = 0;
        while (!(log_q.size() >= 5 && res_valid && res_id == 2'd1) && n < 50) begin
            tick();
            n++;
        end
        chk("t5 restarted word reached", n < 50, 1);
        res_ready = 1'b0;
        chk("t5 restart uses req_cin y", res_y, 16'h0000);
        chk("t5 restart cout", res_cout, 1);
        chk("t5 restart not last", res_last, 0);
        for (int k = 0; k < 5; k++) begin
            chk("t5 id", log_q[k][20:19], t5id[k]);
            chk("t5 last", log_q[k][17], t5l[k]);
            chk("t5 y", log_q[k][15:0], t5y[k]);
        end
        rst = 1'b1;
        #1;
        chk("t5 async reset clears res_valid", res_valid, 0);
        chk("t5 async reset clears req_ready", req_ready, 0);
        do_reset();
        res_ready = 1'b1;
        log_q.delete();
        push(3, 16'h0001, 16'h0001, 1'b0, 1'b1);
        push(0, 16'h0005, 16'h0006, 1'b0, 1'b1);
        wait_idle();
        chk("t5 requester 0 first after reset", log_q[0][20:19], 0);
        chk("t5 requester 0 sum", log_q[0][15:0], 16'h000B);
        chk("t5 requester 3 second", log_q[1][20:19], 3);

        log_q.delete();
        push(0, 16'h7FFF, 16'h0001, 1'b0, 1'b1);
        wait_idle();
        chk("t6 sum", log_q[0][15:0], 16'h8000);
        chk("t6 overflow flag", log_q[0][18], OVF_EN);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    task automatic req_ready_init();
        req_a = '0;
        req_b = '0;
        req_cin = '0;
        req_last = '0;
    endtask
endmodule

// File: doc/add_sched.md
# add_sched

Word-serial scheduler that shares one 16-bit carry-select adder (`CSA16_CLA`) among `N_REQ` requesters. Each requester streams a multi-word addition, least-significant word first. The block arbitrates round-robin, holds the grant for a whole transaction, and chains the carry between words through a register. It returns registered 16-bit partial sums on a valid/ready result port. It sits between operand producers (multi-precision ALU lanes, address generators) and the shared adder.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `MAX_WORDS`, 4: maximum words per transaction; enforces fairness.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous active-high reset.
- `req_valid` in `N_REQ`: per-requester word valid.
- `req_ready` out `N_REQ`: per-requester word accepted; at most one bit high.
- `req_a` in `16*N_REQ`: operand A words; requester i occupies `[16i+15:16i]`.
- `req_b` in `16*N_REQ`: operand B words, same packing as `req_a`.
- `req_cin` in `N_REQ`: carry-in, sampled only on a transaction's first word.
- `req_last` in `N_REQ`: marks the final word of a transaction.
- `res_valid` out 1: result word valid.
- `res_ready` in 1: consumer accepts the result word.
- `res_y` out 16: sum word.
- `res_cout` out 1: carry out of this word.
- `res_id` out `$clog2(N_REQ)`: requester index that owns the result.
- `res_last` out 1: final word of a transaction.
- `res_ovf` out 1: signed overflow on the final word (see Configuration).

## Operation
- States: IDLE, BUSY.
- **IDLE**
  - `req_ready` = 0.
  - If any `req_valid` is high, select the first requester with `req_valid` high, searching from `ptr+1` modulo `N_REQ`.
  - Register it as `grant`, set `first`=1, set `wcnt`=0, go to BUSY.
- **BUSY**
  - `req_ready[grant]` = `~res_valid | res_ready`. All other ready bits are 0.
  - A word is accepted when `req_valid[grant] & req_ready[grant]`.
- **On accept**
  - Adder inputs: `a=req_a[grant]`, `b=req_b[grant]`, `Cin = first ? req_cin[grant] : creg`.
  - Register outputs: `res_y`, `res_cout`, `res_id=grant`, `res_last = req_last[grant] | (wcnt==MAX_WORDS-1)`, `res_valid`=1.
  - Update state: `creg`=Cout, `first`=0, `wcnt`+=1.
- **Transaction end**
  - Triggered when the accepted word has `res_last`=1.
  - Set `ptr`=`grant` and return to IDLE.
  - If the `MAX_WORDS` limit forced termination, the requester's next word starts a new transaction with `Cin=req_cin`.
- **Result port**
  - `res_valid` clears on `res_ready` unless a new word is accepted in the same cycle.
  - While `res_valid & ~res_ready`, all outputs are held stable.
- **Inputs from non-granted requesters**
  - Ignored. Their `req_valid` may stay high indefinitely without effect.
- **Reset values**
  - `res_valid`=0, `res_y`=0, `res_cout`=0, `res_id`=0, `res_last`=0, `res_ovf`=0, `req_ready`=0.
  - Internal: state=IDLE, `ptr`=`N_REQ-1` (requester 0 wins first), `creg`=0, `wcnt`=0.
  - Reset mid-transaction discards the transaction and any pending result.

## Timing
- Arbitration costs one cycle (IDLE) per transaction.
- Accept-to-`res_valid` latency is 1 cycle.
- Throughput is 1 word/cycle while `res_ready`=1.
- Back-to-back transactions: a minimum of 1 idle cycle separates the last word of one transaction from the first word of the next.
- `req_ready` is combinational from `res_valid`/`res_ready` and registered state. There is no combinational path from `req_valid` to `req_ready`.
- Simultaneous `res_ready` and accept in the same cycle: the result register is overwritten and `res_valid` stays 1.

## Configuration
- `ADD_SCHED_OVF_EN` defined:
  - `res_ovf` is registered on accept.
  - `res_ovf = res_last & (a[15]==b[15]) & (sum[15]!=a[15])`.
- `ADD_SCHED_OVF_EN` undefined:
  - `res_ovf` is tied to 0 and no overflow logic is built.
- The port list is identical in both builds.

## Test plan
- **Single word, no carry:** after reset, req0 sends `a=0x1234`, `b=0x0001`, `cin=0`, `last=1`.
  - Expect `res_y=0x1235`, `cout=0`, `id=0`, `last=1`.
  - `res_valid` asserts 2 cycles after `req_valid` (1 arbitration cycle + 1 latency cycle).
- **Carry chain, 3-word:** req2 sends `0xFFFF+0x0001`, then `0xFFFF+0x0000`, then `0x0000+0x0000` (last), with `cin=0`.
  - Expect `y` = `0x0000`, `0x0000`, `0x0001`.
  - Expect `cout` = 1, 1, 0.
- **Round-robin:** requesters 0, 1 and 3 hold `req_valid` with single-word transactions continuously.
  - Grant order after reset is 0, 1, 3, 0, 1, 3.
  - No requester is granted twice before the others.
- **Backpressure:** hold `res_ready`=0 after the first result of a 2-word transaction.
  - `req_ready` drops and `res_y`/`res_cout` stay stable.
  - Raise `res_ready` → the second word is accepted the same cycle, with the carry correctly chained.
- **MAX_WORDS cut and reset:** req1 streams 5 words without `last`.
  - Word 4 returns `res_last=1` and grant moves to a waiting req2.
  - Assert `rst` mid-BUSY → `res_valid`=0 immediately, and after release requester 0 wins first.
- **Overflow (`ADD_SCHED_OVF_EN`):** single word `0x7FFF+0x0001` → `res_ovf=1`. Without the macro → `res_ovf=0`.
